// File: rtl/ustream_acc_if.sv
// rtl/ustream_acc_if.sv - control, unary lane and result bundle for ustream_acc
interface ustream_acc_if #(
    parameter int BW = 10,
    parameter int N  = 1
);
    logic          start;
    logic          clear;
    logic [BW-1:0] win_len;
    logic [N-1:0]  in_bit;
    logic [BW-1:0] q [N];
    logic          out_valid;
    logic          busy;

    modport master (
        output start, clear, win_len, in_bit,
        input  q, out_valid, busy
    );

    modport slave (
        input  start, clear, win_len, in_bit,
        output q, out_valid, busy
    );
endinterface

// File: rtl/ustream_acc.sv
// rtl/ustream_acc.sv - windowed unary bitstream to binary count accumulator array
module ustream_acc #(
    parameter int BW     = 10,
    parameter int WIDTH  = 1,
    parameter int HEIGHT = 1
) (
    input  logic         clk,
    input  logic         rstn,
    ustream_acc_if.slave bus
);
    localparam int N = WIDTH * HEIGHT;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [BW-1:0] rem;
    logic [BW-1:0] acc [N];
    logic [BW-1:0] q_r [N];
    logic          out_valid_r;

    // Window sequencer: launch, count down the window, then publish all lanes at once
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            rem         <= '0;
            out_valid_r <= 1'b0;
            for (int i = 0; i < N; i++) begin
                acc[i] <= '0;
                q_r[i] <= '0;
            end
        end else begin
            out_valid_r <= 1'b0;
            if (bus.clear) begin
                // Abort wins over launch and over the DONE transfer; q keeps the last good result
                state <= S_IDLE;
                rem   <= '0;
                for (int i = 0; i < N; i++) acc[i] <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.start) begin
                            rem <= bus.win_len;
                            for (int i = 0; i < N; i++) acc[i] <= '0;
                            state <= (bus.win_len == '0) ? S_DONE : S_ACC;
                        end
                    end
                    S_ACC: begin
                        // acc never exceeds win_len, so BW bits cannot wrap
                        for (int i = 0; i < N; i++) acc[i] <= acc[i] + BW'(bus.in_bit[i]);
                        rem <= rem - BW'(1);
                        if (rem == BW'(1)) state <= S_DONE;
                    end
                    S_DONE: begin
                        for (int i = 0; i < N; i++) q_r[i] <= acc[i];
                        out_valid_r <= 1'b1;
                        state       <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_q
        assign bus.q[g] = q_r[g];
    end

    assign bus.out_valid = out_valid_r;
    assign bus.busy      = (state != S_IDLE);
endmodule

// File: tb/tb_ustream_acc.sv
// tb/tb_ustream_acc.sv - directed self-checking bench for ustream_acc
module tb_ustream_acc;
    localparam int BW = 4;
    localparam int WIDTH = 2;
    localparam int HEIGHT = 2;
    localparam int N = WIDTH * HEIGHT;

    logic clk;
    logic rstn;
    int   n_cmp;
    int   n_err;
    int   ov_cnt;

    ustream_acc_if #(.BW(BW), .N(N)) bus ();

    ustream_acc #(.BW(BW), .WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_q(input string tag, input int e0, input int e1, input int e2, input int e3);
        int e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int k = 0; k < N; k++) chk($sformatf("%s_q%0d", tag, k), 32'(bus.q[k]), 32'(e[k]));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rstn = 1'b0;
        bus.start = 1'b0;
        bus.clear = 1'b0;
        bus.win_len = '0;
        bus.in_bit = '0;

        // 1. reset state, then L=8 with lane k seeing k+1 leading ones
        step(); step();
        chk_q("rst", 0, 0, 0, 0);
        chk("rst_ov", 32'(bus.out_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        rstn = 1'b1;
        step();
        bus.win_len = 4'd8;
        bus.start = 1'b1;
        bus.in_bit = 4'hF;          // ignored on the start edge
        step();                     // edge E
        bus.start = 1'b0;
        chk("t1_busy_E", 32'(bus.busy), 1);
        chk("t1_ov_E", 32'(bus.out_valid), 0);
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < N; k++) bus.in_bit[k] = (c < k + 1);
            step();                 // edges E+1..E+8
            chk($sformatf("t1_ov_acc%0d", c), 32'(bus.out_valid), 0);
            chk($sformatf("t1_busy_acc%0d", c), 32'(bus.busy), 1);
        end
        bus.in_bit = 4'hF;          // ignored in DONE
        step();                     // edge E+9
        chk("t1_ov_done", 32'(bus.out_valid), 1);
        chk("t1_busy_done", 32'(bus.busy), 0);
        chk_q("t1", 1, 2, 3, 4);
        step();
        chk("t1_ov_after", 32'(bus.out_valid), 0);
        chk_q("t1_hold", 1, 2, 3, 4);

        // 2. full-scale window L=15 all ones, then L=0
        bus.win_len = 4'd15;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.in_bit = 4'hF;
        repeat (15) step();
        chk("t2_ov_pre", 32'(bus.out_valid), 0);
        step();
        chk("t2_ov", 32'(bus.out_valid), 1);
        chk_q("t2", 15, 15, 15, 15);
        bus.win_len = 4'd0;
        bus.start = 1'b1;
        step();                     // E: straight to DONE
        bus.start = 1'b0;
        chk("t2z_busy", 32'(bus.busy), 1);
        chk("t2z_ov_E", 32'(bus.out_valid), 0);
        step();                     // E+1
        chk("t2z_ov", 32'(bus.out_valid), 1);
        chk("t2z_busy_done", 32'(bus.busy), 0);
        chk_q("t2z", 0, 0, 0, 0);
        step();

        // 3. start held high, L=3, per-window pattern 1,0,1 -> period 5, q=2
        bus.win_len = 4'd3;
        bus.start = 1'b1;
        ov_cnt = 0;
        for (int w = 0; w < 3; w++) begin
            bus.in_bit = 4'hF; step();  // E (in_bit ignored)
            chk($sformatf("t3_ov_E_w%0d", w), 32'(bus.out_valid), 0);
            bus.in_bit = 4'hF; step();  // E+1
            bus.in_bit = 4'h0; step();  // E+2
            bus.in_bit = 4'hF; step();  // E+3
            chk($sformatf("t3_ov_pre_w%0d", w), 32'(bus.out_valid), 0);
            bus.in_bit = 4'hF; step();  // E+4 DONE, start ignored while busy
            chk($sformatf("t3_ov_w%0d", w), 32'(bus.out_valid), 1);
            chk_q($sformatf("t3_w%0d", w), 2, 2, 2, 2);
        end
        bus.start = 1'b0;
        step();
        chk("t3_ov_end", 32'(bus.out_valid), 0);
        chk("t3_busy_end", 32'(bus.busy), 0);

        // 4. q=7 from an L=7 window, then clear mid-window of L=10
        bus.win_len = 4'd7;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.in_bit = 4'hF;
        repeat (8) step();
        chk("t4_ov_pre", 32'(bus.out_valid), 1);
        chk_q("t4_pre", 7, 7, 7, 7);
        bus.win_len = 4'd10;
        bus.start = 1'b1;
        step();                     // E
        bus.start = 1'b0;
        step();                     // ACC cycle 1
        bus.clear = 1'b1;
        step();                     // ACC cycle 2 aborted
        bus.clear = 1'b0;
        chk("t4_busy_clr", 32'(bus.busy), 0);
        chk("t4_ov_clr", 32'(bus.out_valid), 0);
        ov_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (bus.out_valid) ov_cnt++;
        end
        chk("t4_no_ov", 32'(ov_cnt), 0);
        chk_q("t4_hold", 7, 7, 7, 7);
        bus.win_len = 4'd1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.in_bit = 4'b0101;
        step();                     // single ACC edge
        bus.in_bit = 4'hF;
        step();
        chk("t4_ov_new", 32'(bus.out_valid), 1);
        chk_q("t4_new", 1, 0, 1, 0);

        // 5. asynchronous reset between edges mid-ACC
        bus.win_len = 4'd10;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step(); step();
        #2 rstn = 1'b0;
        #1;
        chk_q("t5_arst", 0, 0, 0, 0);
        chk("t5_ov", 32'(bus.out_valid), 0);
        chk("t5_busy", 32'(bus.busy), 0);
        #1 rstn = 1'b1;
        step();
        bus.win_len = 4'd2;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.in_bit = 4'hF;
        step(); step();
        chk("t5_ov_pre", 32'(bus.out_valid), 0);
        step();
        chk("t5_ov_new", 32'(bus.out_valid), 1);
        chk_q("t5_new", 2, 2, 2, 2);

        // 6. clear and start together in IDLE: no launch
        bus.win_len = 4'd3;
        bus.start = 1'b1;
        bus.clear = 1'b1;
        step();
        bus.start = 1'b0;
        bus.clear = 1'b0;
        chk("t6_busy", 32'(bus.busy), 0);
        ov_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (bus.out_valid || bus.busy) ov_cnt++;
        end
        chk("t6_idle", 32'(ov_cnt), 0);
        chk_q("t6_hold", 2, 2, 2, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
